conv_maxpool_accum: RTL and testbench

- Downstream stage of the 3x3 systolic convolution block.
- Captures one 2x2 convolution result tile per handshake and reduces it by 2x2 max-pooling.
- Accumulates the pooled value across NUM_CH input-channel tiles with 8-bit saturation.
- Presents the channel-summed feature value on a valid/ready output for the next layer.

---
 rtl/conv_maxpool_accum.sv | 143 ++++++++++++++
 tb/tb_conv_maxpool_accum.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_maxpool_accum.sv
// 2x2 max-pool of a convolution result tile, accumulated with 8-bit saturation
// across NUM_CH channel tiles and emitted on a valid/ready output.
module conv_maxpool_accum #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] result11,
    input  logic [7:0] result12,
    input  logic [7:0] result21,
    input  logic [7:0] result22,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP1 = 2'd1,
        CMP2 = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    r11_q, r11_d, r12_q, r12_d, r21_q, r21_d, r22_q, r22_d;
    logic [DW-1:0]    m0_q, m0_d, m1_q, m1_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;

    logic [DW-1:0]    pooled;
    logic [DW:0]      sum9;
    logic [DW-1:0]    acc_clamped;
    logic             last_ch;

    // Pool/accumulate datapath used in CMP2
    assign pooled      = (m0_q > m1_q) ? m0_q : m1_q;
    assign sum9        = {1'b0, acc_q} + {1'b0, pooled};
    assign acc_clamped = sum9[DW] ? {DW{1'b1}} : sum9[DW-1:0];
    assign last_ch     = (cnt_q == CNT_W'(NUM_CH - 1));

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        r11_d       = r11_q;
        r12_d       = r12_q;
        r21_d       = r21_q;
        r22_d       = r22_q;
        m0_d        = m0_q;
        m1_d        = m1_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    r11_d   = result11;
                    r12_d   = result12;
                    r21_d   = result21;
                    r22_d   = result22;
                    state_d = CMP1;
                end
            end
            CMP1: begin
                m0_d    = (r11_q > r12_q) ? r11_q : r12_q;
                m1_d    = (r21_q > r22_q) ? r21_q : r22_q;
                state_d = CMP2;
            end
            CMP2: begin
                acc_d = acc_clamped;
                sat_d = sat_q | sum9[DW];
                if (last_ch) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_clamped;
                    out_sat_d   = sat_q | sum9[DW];
                    state_d     = OUT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d       = '0;
                    sat_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r11_q       <= '0;
            r12_q       <= '0;
            r21_q       <= '0;
            r22_q       <= '0;
            m0_q        <= '0;
            m1_q        <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r11_q       <= r11_d;
            r12_q       <= r12_d;
            r21_q       <= r21_d;
            r22_q       <= r22_d;
            m0_q        <= m0_d;
            m1_q        <= m1_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_conv_maxpool_accum.sv
// Scoreboard bench for conv_maxpool_accum: one instance with NUM_CH=1, one with NUM_CH=3.
module tb_conv_maxpool_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv1, ir1, ov1, or1, os1;
    logic [7:0] a1, b1, c1, d1, od1;
    logic       iv3, ir3, ov3, or3, os3;
    logic [7:0] a3, b3, c3, d3, od3;

    int checks   = 0;
    int failures = 0;
    int acc3     = 0;

    logic [8:0] q1[$];
    logic [8:0] q3[$];

    conv_maxpool_accum #(.NUM_CH(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .result11(a1), .result12(b1), .result21(c1), .result22(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sat(os1)
    );

    conv_maxpool_accum #(.NUM_CH(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
        .result11(a3), .result12(b3), .result21(c3), .result22(d3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sat(os3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare each completed sum against the scoreboard when out_valid rises
    logic ov1_prev = 1'b0;
    logic ov3_prev = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (ov1 && !ov1_prev) begin
            check("d1_q_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("d1_data", 32'(od1), 32'(e[7:0]));
                check("d1_sat", 32'(os1), 32'(e[8]));
            end
        end
        if (ov3 && !ov3_prev) begin
            check("d3_q_nonempty", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                check("d3_data", 32'(od3), 32'(e[7:0]));
                check("d3_sat", 32'(os3), 32'(e[8]));
            end
        end
        ov1_prev = ov1;
        ov3_prev = ov3;
    end

    // Tile handshakes on the NUM_CH=3 instance
    always @(posedge clk) begin
        if (iv3 && ir3) acc3++;
    end

    task automatic wait_rdy3();
        int n = 0;
        while (!ir3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d3_rdy_timeout", 32'(ir3), 32'd1);
    endtask

    task automatic wait_ov3();
        int n = 0;
        while (!ov3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d3_out_timeout", 32'(ov3), 32'd1);
    endtask

    // Present a tile, keep in_valid high, and confirm the block is busy in CMP1/CMP2
    task automatic send3(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        a3 = a; b3 = b; c3 = c; d3 = d;
        iv3 = 1'b1;
        wait_rdy3();
        @(negedge clk);
        check("d3_cmp1_busy", 32'(ir3), 32'd0);
        @(negedge clk);
        check("d3_cmp2_busy", 32'(ir3), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; c1 = '0; d1 = '0;
        iv3 = 1'b0; or3 = 1'b1; a3 = '0; b3 = '0; c3 = '0; d3 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready_low", 32'(ir1), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_d1_in_ready", 32'(ir1), 32'd1);
        check("rst_d3_in_ready", 32'(ir3), 32'd1);
        check("rst_d1_out_valid", 32'(ov1), 32'd0);
        check("rst_d3_out_valid", 32'(ov3), 32'd0);
        check("rst_d3_out_data", 32'(od3), 32'd0);
        check("rst_d3_out_sat", 32'(os3), 32'd0);

        // NUM_CH=1 single tile with exact latency
        @(negedge clk);
        a1 = 8'd40; b1 = 8'd95; c1 = 8'd17; d1 = 8'd60;
        iv1 = 1'b1;
        q1.push_back({1'b0, 8'd95});
        @(negedge clk);
        iv1 = 1'b0;
        check("d1_cmp1_rdy", 32'(ir1), 32'd0);
        check("d1_cmp1_ov", 32'(ov1), 32'd0);
        @(negedge clk);
        check("d1_cmp2_rdy", 32'(ir1), 32'd0);
        check("d1_cmp2_ov", 32'(ov1), 32'd0);
        @(negedge clk);
        check("d1_out_latency", 32'(ov1), 32'd1);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        check("d1_after_hs_ov", 32'(ov1), 32'd0);
        check("d1_after_hs_rdy", 32'(ir1), 32'd1);

        // NUM_CH=3 channel sum, in_valid held throughout
        q3.push_back({1'b0, 8'd162});
        send3(8'd40, 8'd95, 8'd17, 8'd60);
        send3(8'd10, 8'd5, 8'd60, 8'd2);
        send3(8'd0, 8'd0, 8'd0, 8'd7);
        iv3 = 1'b0;
        wait_ov3();
        check("d3_tiles_consumed", 32'(acc3), 32'd3);
        @(negedge clk);
        check("d3_sum_done_ov", 32'(ov3), 32'd0);

        // Saturation, then a clean sum proving the flag cleared
        q3.push_back({1'b1, 8'd255});
        send3(8'd200, 8'd3, 8'd4, 8'd5);
        send3(8'd1, 8'd100, 8'd2, 8'd3);
        send3(8'd30, 8'd0, 8'd0, 8'd0);
        iv3 = 1'b0;
        wait_ov3();
        @(negedge clk);
        q3.push_back({1'b0, 8'd6});
        send3(8'd1, 8'd0, 8'd0, 8'd0);
        send3(8'd0, 8'd2, 8'd0, 8'd0);
        send3(8'd0, 8'd0, 8'd3, 8'd0);
        iv3 = 1'b0;
        wait_ov3();
        @(negedge clk);

        // Backpressure with a pending tile
        or3 = 1'b0;
        q3.push_back({1'b0, 8'd60});
        send3(8'd10, 8'd0, 8'd0, 8'd0);
        send3(8'd0, 8'd20, 8'd0, 8'd0);
        send3(8'd0, 8'd0, 8'd30, 8'd0);
        a3 = 8'd9; b3 = 8'd1; c3 = 8'd2; d3 = 8'd3;
        q3.push_back({1'b0, 8'd18});
        n = acc3;
        wait_ov3();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_data_held", 32'(od3), 32'd60);
            check("bp_out_valid_held", 32'(ov3), 32'd1);
            check("bp_in_ready_low", 32'(ir3), 32'd0);
            @(negedge clk);
        end
        check("bp_no_tile_taken", 32'(acc3), 32'(n));
        or3 = 1'b1;
        @(negedge clk);
        or3 = 1'b0;
        check("bp_hs_ov", 32'(ov3), 32'd0);
        check("bp_hs_rdy", 32'(ir3), 32'd1);
        check("bp_hs_no_bypass", 32'(acc3), 32'(n));
        @(negedge clk);
        check("bp_pending_taken", 32'(acc3), 32'(n + 1));
        check("bp_pending_busy", 32'(ir3), 32'd0);
        @(negedge clk);
        or3 = 1'b1;
        send3(8'd4, 8'd0, 8'd0, 8'd0);
        send3(8'd0, 8'd5, 8'd0, 8'd0);
        iv3 = 1'b0;
        wait_ov3();
        @(negedge clk);

        // Reset during CMP1 of the second tile discards the partial sum
        send3(8'd50, 8'd0, 8'd0, 8'd0);
        a3 = 8'd0; b3 = 8'd70; c3 = 8'd0; d3 = 8'd0;
        iv3 = 1'b1;
        wait_rdy3();
        @(negedge clk);
        rst = 1'b1;
        iv3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(ir3), 32'd1);
        check("mid_rst_ov", 32'(ov3), 32'd0);
        check("mid_rst_data", 32'(od3), 32'd0);
        check("mid_rst_sat", 32'(os3), 32'd0);
        q3.push_back({1'b0, 8'd3});
        send3(8'd1, 8'd0, 8'd0, 8'd0);
        send3(8'd0, 8'd1, 8'd0, 8'd0);
        send3(8'd0, 8'd0, 8'd0, 8'd1);
        iv3 = 1'b0;
        wait_ov3();
        repeat (3) @(negedge clk);

        check("d1_queue_drained", 32'(q1.size()), 32'd0);
        check("d3_queue_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
